// File: rtl/f_ifu_pkg.sv
// Shared CPU definitions for the fetch stage: default address map and
// exception codes.
package f_ifu_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_LO_DEF      = 32'h0000_3000;
    localparam logic [31:0] IM_HI_DEF      = 32'h0000_6FFC;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    // Fetch address error: misaligned or outside the instruction memory window.
    function automatic logic is_adel(input logic [31:0] pc,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/f_ifu_pc_reg.sv
// 32-bit program counter register with asynchronous reset and write enable.
module f_pc_reg #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] d,
    output logic [31:0] q
);

    logic [31:0] q_r;

    // PC state: reset value on reset, load d when enabled, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r <= RESET_VAL;
        end else if (we) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/f_ifu.sv
// Instruction fetch unit: next-PC selection, instruction memory addressing
// and fetch address error detection.
module f_ifu
    import f_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] IM_LO      = IM_LO_DEF,
    parameter logic [31:0] IM_HI      = IM_HI_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        F_PC_WE,
    input  logic        Req,
    input  logic        D_eret,
    input  logic [31:0] EPC,
    input  logic        D_redirect,
    input  logic [31:0] D_target,
    input  logic        D_is_jb,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] F_Instr,
    output logic [4:0]  F_ExcCode,
    output logic        F_BD
);

    logic [31:0] pc_s;
    logic [31:0] next_pc_s;
    logic        pc_we_s;
    logic        adel_s;

    // Exceptions must be able to leave a stalled pipeline, so Req also enables the write.
    assign pc_we_s = Req | F_PC_WE;

    f_pc_reg #(
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .we    (pc_we_s),
        .d     (next_pc_s),
        .q     (pc_s)
    );

    // Next-PC priority: exception, stall, eret, redirect, sequential.
    always_comb begin
        next_pc_s = pc_s + 32'd4;
        if (Req) begin
            next_pc_s = EXC_VECTOR;
        end else if (!F_PC_WE) begin
            next_pc_s = pc_s;
        end else if (D_eret) begin
            next_pc_s = EPC;
        end else if (D_redirect) begin
            next_pc_s = D_target;
        end else begin
            next_pc_s = pc_s + 32'd4;
        end
    end

    // Address error is judged on the PC actually held, never on an incoming target.
    always_comb begin
        adel_s = is_adel(pc_s, IM_LO, IM_HI);
        if (adel_s) begin
            F_ExcCode = EXC_ADEL;
            F_Instr   = 32'h0000_0000;
        end else begin
            F_ExcCode = EXC_NONE;
            F_Instr   = i_inst_rdata;
        end
    end

    assign F_PC        = pc_s;
    assign i_inst_addr = pc_s;
    assign F_BD        = D_is_jb;

endmodule

// File: doc/f_ifu.md
F_IFU -- requirements
Module: f_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, PC loaded by reset.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h0000_4180, handler entry PC.
REQ-003 SHALL have parameter IM_LO, default 32'h0000_3000, lowest legal fetch address.
REQ-004 SHALL have parameter IM_HI, default 32'h0000_6FFC, highest legal fetch address.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port F_PC_WE  input  1  PC write enable (0 = stall, hold PC).
REQ-008 SHALL have port Req  input  1  exception/interrupt request from CP0.
REQ-009 SHALL have port D_eret  input  1  eret is decoded in D.
REQ-010 SHALL have port EPC  input  32  CP0 return address.
REQ-011 SHALL have port D_redirect  input  1  branch taken or jump resolved in D.
REQ-012 SHALL have port D_target  input  32  redirect target PC.
REQ-013 SHALL have port D_is_jb  input  1  D holds a branch/jump instruction.
REQ-014 SHALL have port i_inst_addr  output  32  instruction memory address (= F_PC).
REQ-015 SHALL have port i_inst_rdata  input  32  instruction memory read data.
REQ-016 SHALL have port F_PC  output  32  current fetch PC.
REQ-017 SHALL have port F_Instr  output  32  fetched instruction toward F/D register.
REQ-018 SHALL have port F_ExcCode  output  5  fetch exception code, 0 = none.
REQ-019 SHALL have port F_BD  output  1  fetched instruction is in a branch delay slot.

Function
REQ-020 SHALL hold F_PC in a 32-bit register updated on clk rising edge.
REQ-021 SHALL select next PC with fixed priority: Req -> EXC_VECTOR; else F_PC_WE=0 -> hold; else D_eret -> EPC; else D_redirect -> D_target; else F_PC + 4.
REQ-022 SHALL let Req override a simultaneous stall, eret or redirect.
REQ-023 SHALL compute F_PC + 4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-024 SHALL drive i_inst_addr = F_PC combinationally, zero latency.
REQ-025 SHALL flag AdEL (F_ExcCode = 5'd4) when F_PC[1:0] != 0 or F_PC < IM_LO or F_PC > IM_HI, else 5'd0.
REQ-026 SHALL force F_Instr = 32'h0 while AdEL is flagged, else F_Instr = i_inst_rdata.
REQ-027 SHALL drive F_BD = D_is_jb combinationally, including during stalls.
REQ-028 SHALL not raise AdEL itself on the redirect that loads an illegal target; the flag appears in the cycle F_PC holds it.
REQ-029 SHALL keep F_PC, F_ExcCode, F_Instr and F_BD stable across any number of stall cycles.

Reset
REQ-030 SHALL set F_PC = RESET_PC immediately on reset assertion, independent of clk.
REQ-031 SHALL produce F_ExcCode = 0 and F_Instr = i_inst_rdata while in reset, given the legal RESET_PC.
REQ-032 SHALL fetch RESET_PC in the first cycle after deassertion and advance on the following edge when F_PC_WE=1.
REQ-033 SHALL discard any pending redirect, eret or Req when reset asserts mid-operation.

Structure
REQ-034 SHALL place RESET_PC, EXC_VECTOR, IM_LO, IM_HI and ExcCode constants (EXC_NONE=0, EXC_ADEL=4) in the shared CPU definitions package.
REQ-035 SHALL contain one sub-module, f_pc_reg: 32-bit register with async reset and write enable.
REQ-036 SHALL keep next-PC mux and AdEL check as combinational logic in f_ifu.

Verification
REQ-037 Reset pulse mid-run, then 3 cycles F_PC_WE=1 -> F_PC = 0x3000, 0x3004, 0x3008, 0x300C; F_ExcCode = 0.
REQ-038 F_PC=0x3010, F_PC_WE=0 for 2 cycles, D_redirect=1 with target 0x3100 -> F_PC holds 0x3010; after stall release, next edge -> 0x3100.
REQ-039 F_PC=0x3020, F_PC_WE=0, Req=1 -> next edge F_PC = 0x4180.
REQ-040 D_eret=1, EPC=0x3050, D_redirect=1 with target 0x3200 -> next F_PC = 0x3050.
REQ-041 D_redirect to 0x3002 -> next cycle F_ExcCode = 4, F_Instr = 0; redirect to 0x7000 -> F_ExcCode = 4.
REQ-042 D_is_jb=1 with F_PC=0x3008 -> F_BD=1 same cycle; D_is_jb=0 -> F_BD=0.
